mem_burst_reader: RTL and testbench
===================================

Name: mem_burst_reader

Overview:
- Read-side initiator for the dual-port stream memory.
- Accepts a burst command (start address, beat count) and issues one read request per cycle on the memory read port (`rd_en`/`rd_addr`).
- Collects the returned words into a small credit-managed FIFO and re-emits them as an AXI-Stream master, with `tlast` on the final beat.
- Sits between the control logic and any downstream stream consumer that drains memory contents.

Parameters:
- ADDR_WIDTH, 12, memory word-address width.
- DATA_WIDTH, 32, data word width; must be a multiple of 8.
- LEN_WIDTH, 8, burst length field width; a burst is cmd_len+1 beats.
- FIFO_DEPTH, 4, return-buffer entries; power of two, at least 2.

Ports:
- axis_aclk  in  1  single clock for all logic.
- axis_areset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_addr  in  ADDR_WIDTH  burst start word address.
- cmd_len  in  LEN_WIDTH  beats minus one.
- mem_rd_en  out  1  read request strobe, one word per asserted cycle.
- mem_rd_addr  out  ADDR_WIDTH  read address, valid while mem_rd_en=1.
- mem_tready  out  1  accept strobe for returned data; held at 1 outside reset.
- mem_rd_tdata  in  DATA_WIDTH  returned word.
- mem_tvalid  in  1  returned word valid.
- m_axis_tdata  out  DATA_WIDTH  output stream data.
- m_axis_tstrb  out  DATA_WIDTH/8  all ones whenever m_axis_tvalid=1.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tlast  out  1  final beat of burst.
- m_axis_tready  in  1  downstream accept.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse after the last beat is accepted downstream.

Behaviour:

Reset (`axis_areset`=1 at a clock edge):
- All outputs go to 0 except `cmd_ready`, which goes to 1.
- FIFO is emptied; outstanding counter and beat counters are cleared; FSM returns to IDLE.
- `mem_tready` is 0 during reset and 1 thereafter.
- Reset mid-burst aborts the burst; no `done` pulse is produced.

State machine IDLE -> ISSUE -> DRAIN -> IDLE:
- IDLE: `cmd_ready`=1. On `cmd_valid`&&`cmd_ready`:
  - latch addr into `rd_ptr`;
  - set `issue_left`=cmd_len+1 and `out_left`=cmd_len+1;
  - go to ISSUE.
  - `busy`=1 from the next cycle.
- ISSUE: `mem_rd_en`=1 in a cycle iff `issue_left`>0 and `outstanding`+`fifo_count` < FIFO_DEPTH (credit rule).
  - Each issue: `rd_ptr`<=`rd_ptr`+1, with modulo 2^ADDR_WIDTH wrap (0xFFF -> 0x000); `issue_left` decrements.
  - `mem_rd_addr` = `rd_ptr` (registered output, driven the same cycle as `mem_rd_en`).
  - When `issue_left` reaches 0, go to DRAIN.
- DRAIN: no further requests. When the beat with `out_left`==1 is accepted downstream, pulse `done`=1 for one cycle, then go to IDLE with `busy`=0.
  - The next command is accepted no earlier than the cycle after `done`.

Memory response side:
- The memory returns one word per request, in order, any latency of 1 cycle or more.
- `mem_tvalid`&&`mem_tready` writes the word into the FIFO.
- `outstanding`+1 on issue, -1 on return, both in the same cycle allowed.
- The credit rule guarantees the FIFO never overflows.
- `mem_tvalid` while `outstanding`==0 (stale data after a reset) is discarded and not written.

Output stream:
- `m_axis_tvalid` = FIFO non-empty; `m_axis_tdata` = FIFO head (first-word fall-through).
- A pop occurs on `m_axis_tvalid`&&`m_axis_tready`; `out_left` decrements on each pop.
- `m_axis_tlast`=1 exactly when `tvalid`=1 and `out_left`==1.
- `tdata`, `tvalid` and `tlast` hold stable while `tvalid`=1 and `tready`=0.
- Simultaneous FIFO push and pop in one cycle leaves `fifo_count` unchanged.
- Full-rate throughput of 1 beat/cycle is required when `tready` is held at 1 and memory latency is at most FIFO_DEPTH-1.

Width and boundary rules:
- cmd_len=0 is a single-beat burst with `tlast` on beat 0.
- cmd_len=2^LEN_WIDTH-1 is a 256-beat burst.
- `cmd_valid` is ignored while `busy`=1.

Test Plan:
1. Reset held 2 cycles, then released -> all outputs 0, `cmd_ready`=1, `mem_tready`=1.
2. Memory model with 1-cycle latency, preloaded mem[a]=0x1000+a. Command addr=0x001, len=3, `tready`=1:
   - `mem_rd_en` high 4 consecutive cycles, addr 0x001..0x004;
   - output 0x1001..0x1004 on 4 back-to-back cycles, `tlast` on 0x1004;
   - `done` pulses once.
3. Wrap-around: command addr=0xFFE, len=3 -> read addresses 0xFFE, 0xFFF, 0x000, 0x001; output 0x1FFE, 0x1FFF, 0x1000, 0x1001.
4. Backpressure: len=7, `tready` low for 10 cycles after the first beat:
   - at most 4 requests are issued before stalling;
   - `tdata` holds 0x1001 during the stall;
   - all 8 beats arrive in order with none lost or duplicated.
5. Single beat: command addr=0x010, len=0 -> one request, one output 0x1010 with `tlast`=1, `done` pulse; a new command is accepted the cycle after `done`.
6. Reset mid-burst (len=15, reset after beat 5) -> outputs clear, `done` never pulses, stale `mem_tvalid` words are discarded, and the next burst len=1 from 0x020 outputs exactly 0x1020, 0x1021.

Source files
------------

// File: rtl/mem_burst_reader.sv
// rtl/mem_burst_reader.sv - burst read initiator: memory read port in, credit-managed FIFO, AXI-Stream master out.
module mem_burst_reader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    axis_aclk,
    input  logic                    axis_areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    output logic                    mem_tready,
    input  logic [DATA_WIDTH-1:0]   mem_rd_tdata,
    input  logic                    mem_tvalid,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic                    busy,
    output logic                    done
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = LEN_WIDTH + 1;

    localparam logic [BEAT_W-1:0]     BEAT_ONE = 1;
    localparam logic [CNT_W-1:0]      CNT_ONE  = 1;
    localparam logic [PTR_W-1:0]      PTR_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [CNT_W:0]        DEPTH_C  = FIFO_DEPTH;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [BEAT_W-1:0]     r_issue_left;
    logic [BEAT_W-1:0]     r_out_left;
    logic [CNT_W-1:0]      r_outstanding;
    logic [CNT_W-1:0]      r_fifo_count;
    logic [PTR_W-1:0]      r_wr_idx;
    logic [PTR_W-1:0]      r_rd_idx;
    logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic                  r_mem_tready;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_last_pop;
    logic                  w_fifo_nonempty;
    logic [CNT_W:0]        w_inflight;

    assign w_fifo_nonempty = (r_fifo_count != '0);
    assign w_pop           = w_fifo_nonempty && m_axis_tready;
    assign w_last_pop      = w_pop && (r_out_left == BEAT_ONE);
    // Returns with nothing outstanding are leftovers from an aborted burst.
    assign w_push          = mem_tvalid && r_mem_tready && (r_outstanding != '0);
    // A slot being popped this cycle is already free, which keeps 1 beat/cycle up to latency DEPTH-1.
    assign w_inflight      = {1'b0, r_outstanding} + {1'b0, r_fifo_count}
                           - {{CNT_W{1'b0}}, w_pop};

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = cmd_valid && !r_done;
                if (w_accept) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_issue = (r_issue_left != '0) && (w_inflight < DEPTH_C);
                if (w_issue && (r_issue_left == BEAT_ONE)) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_pop) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            r_rd_ptr      <= '0;
            r_issue_left  <= '0;
            r_out_left    <= '0;
            r_outstanding <= '0;
            r_fifo_count  <= '0;
            r_wr_idx      <= '0;
            r_rd_idx      <= '0;
            r_mem_tready  <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_mem_tready <= 1'b1;
            r_done       <= (r_state == S_DRAIN) && w_last_pop;

            if (w_pop) begin
                r_out_left <= r_out_left - BEAT_ONE;
            end
            if (w_accept) begin
                r_rd_ptr     <= cmd_addr;
                r_issue_left <= {1'b0, cmd_len} + BEAT_ONE;
                r_out_left   <= {1'b0, cmd_len} + BEAT_ONE;
            end else if (w_issue) begin
                r_rd_ptr     <= r_rd_ptr + ADDR_ONE;
                r_issue_left <= r_issue_left - BEAT_ONE;
            end

            case ({w_issue, w_push})
                2'b10:   r_outstanding <= r_outstanding + CNT_ONE;
                2'b01:   r_outstanding <= r_outstanding - CNT_ONE;
                default: r_outstanding <= r_outstanding;
            endcase

            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + CNT_ONE;
                2'b01:   r_fifo_count <= r_fifo_count - CNT_ONE;
                default: r_fifo_count <= r_fifo_count;
            endcase

            if (w_push) begin
                r_wr_idx <= r_wr_idx + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_idx <= r_rd_idx + PTR_ONE;
            end
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (w_push) begin
            r_fifo[r_wr_idx] <= mem_rd_tdata;
        end
    end

    assign cmd_ready     = (r_state == S_IDLE) && !r_done;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign mem_rd_en     = w_issue;
    assign mem_rd_addr   = r_rd_ptr;
    assign mem_tready    = r_mem_tready;
    assign m_axis_tvalid = w_fifo_nonempty;
    assign m_axis_tdata  = w_fifo_nonempty ? r_fifo[r_rd_idx] : '0;
    assign m_axis_tstrb  = {(DATA_WIDTH/8){w_fifo_nonempty}};
    assign m_axis_tlast  = w_fifo_nonempty && (r_out_left == BEAT_ONE);
endmodule

// File: tb/tb_mem_burst_reader.sv
// tb/tb_mem_burst_reader.sv - randomized scoreboard bench for mem_burst_reader.
module tb_mem_burst_reader;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_tready;
    logic [DW-1:0] mem_rd_tdata = '0;
    logic          mem_tvalid = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic [DW/8-1:0] m_axis_tstrb;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic          busy;
    logic          done;

    mem_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)) dut (
        .axis_aclk(clk), .axis_areset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_tready(mem_tready),
        .mem_rd_tdata(mem_rd_tdata), .mem_tvalid(mem_tvalid),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct { logic [AW-1:0] addr; int due; } rsp_t;

    beat_t         exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    rsp_t          mem_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat     = 1;
    int tr_mode = 0;
    int n_req   = 0;
    int n_pop   = 0;
    int first_pop, last_pop, first_req, last_req;
    int done_due = -1;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    beat_t         mon_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (tr_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ($urandom_range(0, 3) != 0);
            default: m_axis_tready = 1'b0;
        endcase
    end

    // Memory: mem[a] = 0x1000 + a, in-order responses after a fixed latency; keeps running through reset.
    always @(negedge clk) begin
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            mem_tvalid   = 1'b1;
            mem_rd_tdata = 32'h1000 + {20'h0, mem_q[0].addr};
            void'(mem_q.pop_front());
        end else begin
            mem_tvalid   = 1'b0;
            mem_rd_tdata = $urandom;
        end
        if (mem_rd_en) mem_q.push_back('{mem_rd_addr, cyc + lat});
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_tvalid", m_axis_tvalid, 1);
                check("hold_tdata", m_axis_tdata, prev_data);
                check("hold_tlast", m_axis_tlast, prev_last);
            end
            if (m_axis_tvalid) check("tstrb", m_axis_tstrb, 4'hF);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL beat: unexpected beat 0x%0h, none required", m_axis_tdata);
                end else begin
                    mon_b = exp_q.pop_front();
                    check("tdata", m_axis_tdata, mon_b.data);
                    check("tlast", m_axis_tlast, mon_b.last);
                    if (mon_b.last) done_due = cyc + 1;
                end
                if (n_pop == 0) first_pop = cyc;
                last_pop = cyc;
                n_pop++;
            end
            if (mem_rd_en) begin
                if (exp_addr_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rd_addr: unexpected request at 0x%0h, none required", mem_rd_addr);
                end else begin
                    check("rd_addr", mem_rd_addr, exp_addr_q.pop_front());
                end
                if (n_req == 0) first_req = cyc;
                last_req = cyc;
                n_req++;
                check("credit", (n_req - n_pop) <= FD, 1);
            end
            if (done || cyc == done_due) check("done_pulse", done, cyc == done_due);
            if (done) check("cmd_ready_at_done", cmd_ready, 0);
            if (done_due >= 0 && cyc == done_due + 1) check("cmd_ready_after_done", cmd_ready, 1);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_rd_addr", mem_rd_addr, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tstrb", m_axis_tstrb, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_tready", mem_tready, 0);
        @(negedge clk);
        check("post_rst_mem_tready", mem_tready, 1);
        check("post_rst_cmd_ready", cmd_ready, 1);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        rst = 1'b1;
        cmd_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        n_req = 0;
        n_pop = 0;
        done_due = -1;
    endtask

    task automatic send_burst(input logic [AW-1:0] a, input int len);
        logic [AW-1:0] ai;
        logic ok;
        int t;
        for (int i = 0; i <= len; i++) begin
            ai = a + AW'(i);
            exp_q.push_back('{32'h1000 + {20'h0, ai}, i == len});
            exp_addr_q.push_back(ai);
        end
        n_req = 0;
        n_pop = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = LW'(len);
        t = 0;
        do begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk); #1;
            t++;
        end while (!ok && t < 300);
        cmd_valid = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_len   = LW'($urandom);
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL cmd_accept: cmd_ready stayed 0 for %0d cycles, required 1", t);
        end
        @(negedge clk);
        check("busy_after_cmd", busy, 1);
    endtask

    task automatic wait_burst(input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL burst_timeout: %0d beats missing, required 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        check("busy_idle", busy, 0);
        check("rd_addr_left", exp_addr_q.size(), 0);
    endtask

    task automatic check_full_rate(input int len);
        check("beat_span", last_pop - first_pop, len);
        check("req_span", last_req - first_req, len);
    endtask

    initial begin
        int len;
        logic [AW-1:0] a;
        int t;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs();

        lat = 1; tr_mode = 0;
        send_burst(12'h001, 3);
        wait_burst(200);
        check_full_rate(3);

        send_burst(12'hFFE, 3);
        wait_burst(200);
        check_full_rate(3);

        tr_mode = 2;
        send_burst(12'h001, 7);
        t = 0;
        while (!m_axis_tvalid && t < 50) begin
            @(posedge clk);
            t++;
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_reqs_le_depth", n_req <= FD, 1);
        check("stall_tdata", m_axis_tdata, 32'h1001);
        check("stall_pops", n_pop, 0);
        tr_mode = 0;
        wait_burst(300);

        send_burst(12'h010, 0);
        wait_burst(100);
        check("single_pops", n_pop, 1);
        send_burst(12'h011, 0);
        wait_burst(100);

        lat = 2;
        send_burst(12'h000, 15);
        t = 0;
        while (n_pop < 6 && t < 200) begin
            @(posedge clk);
            t++;
        end
        do_reset(2);
        check_reset_outputs();
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("stale_discard_tvalid", m_axis_tvalid, 0);
        check("stale_no_pops", n_pop, 0);
        lat = 1;
        send_burst(12'h020, 1);
        wait_burst(100);
        check("post_abort_pops", n_pop, 2);

        for (int k = 0; k < 24; k++) begin
            len = (k == 5) ? 255 : $urandom_range(0, 12);
            a = AW'($urandom);
            lat = $urandom_range(1, FD - 1);
            tr_mode = (k == 5) ? 0 : $urandom_range(0, 1);
            send_burst(a, len);
            wait_burst(3000);
            check("burst_pops", n_pop, len + 1);
            if (tr_mode == 0) check_full_rate(len);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
